// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the P7 coprocessor-0.
//   - CP0 register numbers used by mfc0/mtc0 decoding.
//   - Exception codes carried down the pipeline in ExcCodeIn.
//   - Trap handler vector used by the fetch unit when Req is taken.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Exception codes
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // Trap handler entry point
  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

  // EPC always holds a word-aligned address
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0.sv
// cp0: Coprocessor-0 beside the M stage of the P7 pipelined MIPS core.
// Decides whether to take a trap (interrupt or exception), records the return
// address and cause, and services mfc0/mtc0/eret.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   en              - mtc0 write enable (M stage)
//   CP0Add, CP0In   - CP0 register number and mtc0 write data
//   VPC, BDIn       - M-stage PC and branch-delay-slot flag
//   ExcCodeIn       - pipelined exception code, 0 = none
//   HWInt           - external interrupt lines
//   EXLClr          - eret retiring in M stage
//   CP0Out          - mfc0 read data
//   EPCOut          - current EPC register (no forwarding)
//   Req             - take trap this cycle (combinational)
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_2001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  // SR fields
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  // Cause fields
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  // EPC
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic [31:0] w_trap_epc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (ExcCodeIn != EXC_INT) & ~r_exl;
  assign Req       = w_int_req | w_exc_req;

  // A delay-slot instruction restarts at its branch
  assign w_trap_epc = word_align(BDIn ? (VPC - 32'd4) : VPC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_ip <= HWInt;
      if (Req) begin
        // Trap entry; any mtc0 in the same cycle is dropped
        r_exl      <= 1'b1;
        r_bd       <= BDIn;
        r_exc_code <= w_int_req ? EXC_INT : ExcCodeIn;
        r_epc      <= w_trap_epc;
      end else begin
        if (EXLClr) begin
          r_exl <= 1'b0;
        end
        // Placed after EXLClr so an mtc0 to SR decides EXL
        if (en) begin
          case (CP0Add)
            REG_SR: begin
              r_im  <= CP0In[15:10];
              r_exl <= CP0In[1];
              r_ie  <= CP0In[0];
            end
            REG_EPC: r_epc <= word_align(CP0In);
            default: ;
          endcase
        end
      end
    end
  end

  assign w_sr    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
  assign w_cause = {r_bd, 15'h0000, r_ip, 3'b000, r_exc_code, 2'b00};

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      REG_SR:    CP0Out = w_sr;
      REG_CAUSE: CP0Out = w_cause;
      REG_EPC:   CP0Out = r_epc;
      REG_PRID:  CP0Out = PRID;
      default:   CP0Out = '0;
    endcase
  end

  assign EPCOut = r_epc;

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: self-checking bench for cp0. A word-level model of SR/Cause/EPC
// tracks the expected state; directed scenarios are followed by random traffic.
module tb_cp0;

  localparam logic [31:0] PRID_VAL = 32'h0000_2001;

  logic        clk = 1'b0;
  logic        reset, en, BDIn, EXLClr;
  logic [4:0]  CP0Add, ExcCodeIn;
  logic [31:0] CP0In, VPC;
  logic [5:0]  HWInt;
  logic [31:0] CP0Out, EPCOut;
  logic        Req;

  int checks = 0;
  int errors = 0;

  // Model state as architectural words
  logic [31:0] m_sr, m_cause, m_epc;

  cp0 #(.PRID(PRID_VAL)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In), .VPC(VPC),
    .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  function automatic logic m_int();
    return (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      default: return 32'h0;
    endcase
  endfunction

  // Next architectural state from the current inputs
  task automatic model_step();
    logic [31:0] ret;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause[15:10] = HWInt;
      if (m_req()) begin
        ret = BDIn ? VPC - 32'd4 : VPC;
        m_cause[31]  = BDIn;
        m_cause[6:2] = m_int() ? 5'd0 : ExcCodeIn;
        m_sr[1]      = 1'b1;
        m_epc        = ret & 32'hFFFF_FFFC;
      end else begin
        if (EXLClr) m_sr[1] = 1'b0;
        if (en && CP0Add == 5'd12) m_sr = CP0In & 32'h0000_FC03;
        if (en && CP0Add == 5'd14) m_epc = CP0In & 32'hFFFF_FFFC;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; en = 0; BDIn = 0; EXLClr = 0; CP0Add = 0; ExcCodeIn = 0;
    CP0In = 0; VPC = 32'h0000_3000; HWInt = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd = '{32'h0, 32'h0, 32'h0, PRID_VAL};
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      CP0Add = 5'(12 + i);
      #1;
      checks++;
      if (CP0Out !== exp_rd[i]) begin
        errors++;
        $display("FAIL reset_read reg %0d got %h exp %h", 12 + i, CP0Out, exp_rd[i]);
      end
    end
    checks++;
    if (Req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", Req); end
  endtask

  task automatic test_hwint_ip();
    HWInt = 6'b000100;
    #1;
    checks++;
    if (Req !== 1'b0) begin errors++; $display("FAIL ip_masked_req got %b exp 0", Req); end
    tick();
    CP0Add = 5'd13;
    #1;
    checks++;
    if (CP0Out !== 32'h0000_1000) begin
      errors++; $display("FAIL ip_cause got %h exp 00001000", CP0Out);
    end
    HWInt = 0;
  endtask

  task automatic test_int_trap();
    en = 1; CP0Add = 5'd12; CP0In = 32'h0000_0401; HWInt = 6'b000001; VPC = 32'h0000_3010;
    tick();
    en = 0;
    #1;
    checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL int_req got %b exp 1", Req); end
    tick();
    CP0Add = 5'd12;
    #1;
    checks++;
    if (CP0Out !== 32'h0000_0403) begin errors++; $display("FAIL int_sr got %h exp 00000403", CP0Out); end
    CP0Add = 5'd13;
    #1;
    checks++;
    if (CP0Out !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got %h exp 00000400", CP0Out); end
    checks++;
    if (EPCOut !== 32'h0000_3010) begin errors++; $display("FAIL int_epc got %h exp 00003010", EPCOut); end
    checks++;
    if (Req !== 1'b0) begin errors++; $display("FAIL int_req_drop got %b exp 0", Req); end
  endtask

  task automatic test_eret();
    EXLClr = 1;
    tick();
    EXLClr = 0;
    CP0Add = 5'd12;
    #1;
    checks++;
    if (CP0Out !== 32'h0000_0401) begin errors++; $display("FAIL eret_sr got %h exp 00000401", CP0Out); end
    checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL eret_rereq got %b exp 1", Req); end
    tick();  // take the re-raised interrupt, EXL set again
  endtask

  task automatic test_exc_bd();
    en = 1; CP0Add = 5'd12; CP0In = 32'h0; HWInt = 0;
    tick();
    en = 0; ExcCodeIn = 5'd12; BDIn = 1; VPC = 32'h0000_3024;
    #1;
    checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL ov_req got %b exp 1", Req); end
    tick();
    CP0Add = 5'd13;
    #1;
    checks++;
    if (EPCOut !== 32'h0000_3020) begin errors++; $display("FAIL ov_epc got %h exp 00003020", EPCOut); end
    checks++;
    if (CP0Out !== 32'h8000_0030) begin errors++; $display("FAIL ov_cause got %h exp 80000030", CP0Out); end
    ExcCodeIn = 5'd5; BDIn = 0; VPC = 32'h0000_3100;
    #1;
    checks++;
    if (Req !== 1'b0) begin errors++; $display("FAIL exl_mask_req got %b exp 0", Req); end
    tick();
    checks++;
    if (EPCOut !== 32'h0000_3020) begin errors++; $display("FAIL exl_mask_epc got %h exp 00003020", EPCOut); end
    ExcCodeIn = 0;
  endtask

  task automatic test_priority();
    en = 1; CP0Add = 5'd12; CP0In = 32'h0000_0401; HWInt = 6'b000001;
    tick();
    en = 0; ExcCodeIn = 5'd10; VPC = 32'h0000_3200;
    tick();
    CP0Add = 5'd13;
    #1;
    checks++;
    if (CP0Out[6:2] !== 5'd0) begin errors++; $display("FAIL prio_exccode got %0d exp 0", CP0Out[6:2]); end
    checks++;
    if (EPCOut !== 32'h0000_3200) begin errors++; $display("FAIL prio_epc got %h exp 00003200", EPCOut); end
    ExcCodeIn = 0;
  endtask

  task automatic test_mtc0_epc();
    en = 1; CP0Add = 5'd14; CP0In = 32'h0000_3007;
    tick();
    en = 0;
    checks++;
    if (EPCOut !== 32'h0000_3004) begin errors++; $display("FAIL mtc0_epc got %h exp 00003004", EPCOut); end
  endtask

  task automatic test_req_vs_mtc0();
    en = 1; CP0Add = 5'd12; CP0In = 32'h0000_0401; HWInt = 6'b000001;
    tick();
    CP0In = 32'h0;  // mtc0 12 <- 0 while Req = 1
    #1;
    checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL rvm_req got %b exp 1", Req); end
    tick();
    en = 0;
    #1;
    checks++;
    if (CP0Out !== 32'h0000_0403) begin errors++; $display("FAIL rvm_sr got %h exp 00000403", CP0Out); end
  endtask

  task automatic test_reset_midtrap();
    EXLClr = 1;
    tick();
    EXLClr = 0; reset = 1; en = 1; CP0Add = 5'd14; CP0In = 32'h1234_5678; VPC = 32'h0000_3300;
    #1;
    checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL rst_mid_req got %b exp 1", Req); end
    tick();
    reset = 0; en = 0; HWInt = 0;
    for (int a = 12; a <= 14; a++) begin
      CP0Add = 5'(a);
      #1;
      checks++;
      if (CP0Out !== 32'h0) begin errors++; $display("FAIL rst_mid reg %0d got %h exp 0", a, CP0Out); end
    end
    checks++;
    if (Req !== 1'b0) begin errors++; $display("FAIL rst_mid_req_after got %b exp 0", Req); end
  endtask

  task automatic test_random();
    logic [4:0] exp_list [5];
    exp_list = '{5'd0, 5'd4, 5'd8, 5'd10, 5'd12};
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      en        = ($urandom_range(0, 3) == 0);
      CP0Add    = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      CP0In     = $urandom;
      VPC       = $urandom;
      BDIn      = 1'($urandom);
      ExcCodeIn = ($urandom_range(0, 5) == 0) ? exp_list[$urandom_range(1, 4)] : 5'd0;
      HWInt     = 6'($urandom);
      EXLClr    = ($urandom_range(0, 4) == 0);
      #1;
      checks++;
      if (Req !== m_req()) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", n, Req, m_req()); end
      checks++;
      if (CP0Out !== m_read(CP0Add)) begin
        errors++; $display("FAIL rnd_rd cyc %0d reg %0d got %h exp %h", n, CP0Add, CP0Out, m_read(CP0Add));
      end
      checks++;
      if (EPCOut !== m_epc) begin errors++; $display("FAIL rnd_epc cyc %0d got %h exp %h", n, EPCOut, m_epc); end
      tick();
    end
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_hwint_ip();
    test_int_trap();
    test_eret();
    test_exc_bd();
    test_priority();
    test_mtc0_epc();
    test_req_vs_mtc0();
    test_reset_midtrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0.md
Name: cp0

Overview:
- Coprocessor-0 for the P7 pipelined MIPS core; sits beside the M stage.
- Collects the exception code and hardware interrupt lines, and decides whether to take a trap.
- Drives the trap request (Req) and the saved return address (EPC) consumed by the instruction-fetch unit.
- Services mfc0/mtc0 accesses and eret (EXL clear).

Parameters:
- PRID, 32'h0000_2001, reset/constant value of the read-only PRId register (reg 15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  mtc0 write enable, from M stage.
- CP0Add  in  5  CP0 register number for mfc0/mtc0.
- CP0In  in  32  mtc0 write data.
- VPC  in  32  PC of the M-stage instruction (macroscopic PC).
- BDIn  in  1  M-stage instruction is in a branch delay slot.
- ExcCodeIn  in  5  pipelined exception code; 0 = none.
- HWInt  in  6  external interrupt lines; bit0 = timer0, bit1 = timer1, bit2 = interrupt generator.
- EXLClr  in  1  eret retiring in M stage.
- CP0Out  out  32  mfc0 read data.
- EPCOut  out  32  current EPC register.
- Req  out  1  take trap this cycle; the fetch unit jumps to 0x4180 and the pipeline flushes.

Behaviour:
- Registers:
  - SR (12): IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
  - Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]; other bits 0.
  - EPC (14): 32 bits.
  - PRId (15): constant PRID.
- Reset (sync, clk edge with reset = 1): SR = 0, Cause = 0, EPC = 0. Req = 0 follows combinationally.
- IntReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
- Req = IntReq | ExcReq. Purely combinational, zero latency, same cycle as the inputs.
- Cause.IP <= HWInt on every non-reset edge, regardless of Req or EXL.
- On an edge with Req = 1:
  - SR.EXL <= 1.
  - Cause.BD <= BDIn.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn. An interrupt has priority over a simultaneous exception.
  - EPC <= BDIn ? VPC - 4 : VPC, then bits [1:0] forced to 0.
  - The mtc0 write is suppressed that cycle, even if en = 1.
- On an edge with Req = 0 and EXLClr = 1: SR.EXL <= 0.
  - EXLClr with Req = 1 cannot occur architecturally (EXL = 1 masks Req). If it does, Req wins.
- mtc0 (en = 1, Req = 0):
  - CP0Add = 12: SR.IM <= CP0In[15:10], SR.EXL <= CP0In[1], SR.IE <= CP0In[0].
  - CP0Add = 14: EPC <= CP0In with [1:0] forced 0.
  - Writes to 13, 15 or any other address are ignored.
  - If en and EXLClr are asserted together with CP0Add = 12, the mtc0 value of EXL wins.
- mfc0: CP0Out = register selected by CP0Add (combinational); unimplemented addresses read 0.
- EPCOut = EPC register, with no internal forwarding. The hazard unit stalls an eret in D while an mtc0 to EPC is in E/M.
- Reset asserted mid-trap: reset wins over Req, EXLClr and en.
- Arithmetic: VPC - 4 is 32-bit wrap-around with no overflow detection.

Decomposition:
- Shared package:
  - Register-number constants: SR = 12, CAUSE = 13, EPC = 14, PRID = 15.
  - ExcCode constants: INT = 0, ADEL = 4, ADES = 5, SYSCALL = 8, RI = 10, OV = 12.
  - Handler vector 32'h0000_4180.
- No sub-module needed; a single flat module of roughly 150 lines.

Test Plan:
- Reset, then mfc0 of 12/13/14/15 -> 0, 0, 0, PRID.
  - Drive HWInt = 6'b000100 with SR = 0 -> Req = 0; the next mfc0 13 reads 32'h0000_1000.
- mtc0 12 <- 32'h0000_0401 (IM[10], IE) with HWInt[0] = 1 -> Req = 1 the same cycle. After the edge:
  - SR.EXL = 1.
  - Cause.ExcCode = 0.
  - EPC = VPC (VPC = 32'h0000_3010 -> EPC = 32'h0000_3010).
  - Req drops to 0.
- ExcCodeIn = 12 (Ov) with BDIn = 1 and VPC = 32'h0000_3024 -> Req = 1. After the edge:
  - EPC = 32'h0000_3020.
  - Cause = 32'h8000_0030.
- Simultaneous enabled interrupt and ExcCodeIn = 10 -> ExcCode latched 0. A second ExcCodeIn while EXL = 1 -> Req = 0 and EPC unchanged.
- EXLClr for one cycle after a trap -> EXL = 0 and the pending enabled interrupt re-raises Req on the next cycle.
  - mtc0 14 <- 32'h0000_3007 -> EPCOut = 32'h0000_3004.
- Req and en (mtc0 12 <- 0) in the same cycle -> SR keeps IM/IE and gains EXL = 1.
  - Reset asserted in the same cycle as Req -> all registers 0.
